// File: rtl/pcie_tx_pkg.sv
// Shared constants and types for the PCIe TX virtual-channel arbiter.
package pcie_tx_pkg;

    localparam int TLP_W_DEF = 224;
    localparam int MAX_VC    = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Rotated find-first-set: returns the first asserted request at or above ptr, wrapping at N-1.
module arb_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any
);

    always_comb begin
        int               sum;
        logic [IDX_W-1:0] idx;
        sum   = 0;
        idx   = '0;
        grant = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            sum = int'(ptr) + i;
            idx = IDX_W'((sum >= N) ? sum - N : sum);
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/arb_wrr_tlp.sv
// Weighted round-robin arbiter moving TLPs from NUM_VC show-ahead FIFOs into a registered output stage.
// Build option ARB_STRICT_VC0_EN: a non-empty VC0 pre-empts every round-robin decision.
//
// state    | meaning
// ST_IDLE  | no owner; grant by rotated search starting at ptr
// ST_BURST | cur_vc owns the link while it is non-empty and cnt credits remain
module arb_wrr_tlp
    import pcie_tx_pkg::*;
#(
    parameter int NUM_VC   = 4,
    parameter int TLP_W    = TLP_W_DEF,
    parameter int WEIGHT_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_VC-1:0]          vc_empty,
    input  logic [NUM_VC*TLP_W-1:0]    vc_data,
    input  logic [NUM_VC*WEIGHT_W-1:0] vc_weight,
    output logic [NUM_VC-1:0]          vc_rd_en,
    output logic [TLP_W-1:0]           tlp_o,
    output logic                       tlp_valid_o,
    input  logic                       tlp_ready_i
);

    localparam int               IDX_W   = $clog2(NUM_VC);
    localparam logic [IDX_W-1:0] LAST_VC = IDX_W'(NUM_VC - 1);

    arb_state_t          state, state_nxt;
    logic [IDX_W-1:0]    cur_vc, cur_vc_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [IDX_W-1:0]    pick_ptr, pick_grant, grant;
    logic [WEIGHT_W-1:0] cnt, cnt_nxt, w_sel;
    logic                load, burst_cont, pick_any, grant_any, capture, strict_hit;

    assign load       = !tlp_valid_o || tlp_ready_i;
    assign burst_cont = (state == ST_BURST) && !vc_empty[cur_vc] && (cnt != '0);

    // When a burst ends the search starts just past the old owner in the same cycle.
    assign pick_ptr = (state == ST_BURST) ? ((cur_vc == LAST_VC) ? '0 : cur_vc + 1'b1) : ptr;

    arb_rr_pick #(
        .N     (NUM_VC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (~vc_empty),
        .ptr   (pick_ptr),
        .grant (pick_grant),
        .any   (pick_any)
    );

`ifdef ARB_STRICT_VC0_EN
    assign strict_hit = !vc_empty[0];
`else
    assign strict_hit = 1'b0;
`endif

    always_comb begin
        grant     = pick_grant;
        grant_any = pick_any;
        if (strict_hit) begin
            grant     = '0;
            grant_any = 1'b1;
        end else if (burst_cont) begin
            grant     = cur_vc;
            grant_any = 1'b1;
        end
    end

    assign capture = !rst && load && grant_any;
    assign w_sel   = vc_weight[int'(grant)*WEIGHT_W +: WEIGHT_W];

    always_comb begin
        vc_rd_en = '0;
        if (capture) vc_rd_en[grant] = 1'b1;
    end

    always_comb begin
        state_nxt  = state;
        cur_vc_nxt = cur_vc;
        cnt_nxt    = cnt;
        ptr_nxt    = ptr;
        if (load && strict_hit) begin
            // VC0 service drops any burst but leaves ptr and credits untouched.
            state_nxt = ST_IDLE;
        end else if (load) begin
            if (burst_cont) begin
                cnt_nxt = cnt - 1'b1;
            end else begin
                if (state == ST_BURST) ptr_nxt = pick_ptr;
                if (pick_any) begin
                    state_nxt  = ST_BURST;
                    cur_vc_nxt = pick_grant;
                    cnt_nxt    = (w_sel == '0) ? '0 : w_sel - 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur_vc      <= '0;
            cnt         <= '0;
            ptr         <= '0;
            tlp_valid_o <= 1'b0;
            tlp_o       <= '0;
        end else begin
            state  <= state_nxt;
            cur_vc <= cur_vc_nxt;
            cnt    <= cnt_nxt;
            ptr    <= ptr_nxt;
            if (capture) begin
                tlp_o       <= vc_data[int'(grant)*TLP_W +: TLP_W];
                tlp_valid_o <= 1'b1;
            end else if (load) begin
                tlp_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_wrr_tlp.sv
// Bench for arb_wrr_tlp: queue-based FIFO model plus a rule-level arbitration reference.
module tb_arb_wrr_tlp;

    localparam int N  = 4;
    localparam int TW = 224;
    localparam int WW = 4;

    typedef logic [TW-1:0] tlp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rdy = 1'b1;
    logic [N-1:0]    vc_empty;
    logic [N*TW-1:0] vc_data;
    logic [N*WW-1:0] vc_weight;
    logic [N-1:0]    vc_rd_en;
    tlp_t            tlp_o;
    logic            tlp_valid_o;

    int total = 0;
    int bad   = 0;

    tlp_t q[N][$];
    int   w[N];

    int   m_owner = -1;
    int   m_left  = 0;
    int   m_ptr   = 0;
    logic m_valid = 1'b0;
    tlp_t m_data  = '0;

    logic [N-1:0] rd_o, rd_e;
    logic         v_o, v_e;
    tlp_t         d_o, d_e;
    int           g_o;

    always #5 clk = ~clk;

    arb_wrr_tlp #(
        .NUM_VC   (N),
        .TLP_W    (TW),
        .WEIGHT_W (WW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vc_empty    (vc_empty),
        .vc_data     (vc_data),
        .vc_weight   (vc_weight),
        .vc_rd_en    (vc_rd_en),
        .tlp_o       (tlp_o),
        .tlp_valid_o (tlp_valid_o),
        .tlp_ready_i (rdy)
    );

    function automatic tlp_t rnd_tlp();
        tlp_t t;
        for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom();
        return t;
    endfunction

    function automatic int oh_idx(logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = (r == -1) ? i : -2;
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            vc_empty[i]          = (q[i].size() == 0);
            vc_data[i*TW +: TW]  = (q[i].size() != 0) ? q[i][0] : rnd_tlp();
            vc_weight[i*WW +: WW] = WW'(w[i]);
        end
    endtask

    // One clock: drive FIFO heads, predict the pop from the arbitration rules, advance the model.
    task automatic cycle();
        int   g, p, nown, nleft, nptr;
        logic load;
        @(negedge clk);
        drive();
        #1;
        rd_o  = vc_rd_en;
        g     = -1;
        nown  = m_owner;
        nleft = m_left;
        nptr  = m_ptr;
        load  = !m_valid || rdy;
        if (!rst && load) begin
`ifdef ARB_STRICT_VC0_EN
            if (q[0].size() != 0) begin
                g    = 0;
                nown = -1;
            end
`endif
            if (g < 0 && m_owner >= 0 && m_left > 0 && q[m_owner].size() != 0) begin
                g     = m_owner;
                nleft = m_left - 1;
            end else if (g < 0) begin
                if (m_owner >= 0) nptr = (m_owner + 1) % N;
                nown = -1;
                for (int k = 0; k < N; k++) begin
                    p = (nptr + k) % N;
                    if (nown < 0 && q[p].size() != 0) begin
                        g     = p;
                        nown  = p;
                        nleft = (w[p] == 0) ? 0 : w[p] - 1;
                    end
                end
            end
        end
        rd_e = '0;
        if (g >= 0) rd_e[g] = 1'b1;
        @(posedge clk);
        #1;
        if (rst) begin
            m_owner = -1;
            m_left  = 0;
            m_ptr   = 0;
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            if (g >= 0) begin
                m_data  = q[g].pop_front();
                m_valid = 1'b1;
            end else if (load) begin
                m_valid = 1'b0;
            end
            m_owner = nown;
            m_left  = nleft;
            m_ptr   = nptr;
        end
        v_e = m_valid;
        d_e = m_data;
        v_o = tlp_valid_o;
        d_o = tlp_o;
        g_o = oh_idx(rd_o);
    endtask

    task automatic restart(input int w0, input int w1, input int w2, input int w3);
        for (int i = 0; i < N; i++) q[i].delete();
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        rst = 1'b1;
        rdy = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            repeat (3) q[i].push_back(rnd_tlp());
            w[i] = 1;
        end
        rst = 1'b1;
        rdy = 1'b1;
        cycle();
        cycle();
        total++; if (rd_o !== '0)  begin bad++; $display("FAIL reset_rd_en: got %b want 0", rd_o); end
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", v_o); end
        total++; if (d_o !== d_e)  begin bad++; $display("FAIL reset_tlp: got %h want %h", d_o, d_e); end
        rst = 1'b0;
    endtask

    task automatic test_equal_weights();
        restart(1, 1, 1, 1);
        for (int i = 0; i < N; i++) repeat (12) q[i].push_back(rnd_tlp());
        for (int c = 0; c < 12; c++) begin
            cycle();
            total++; if (g_o !== c % N) begin bad++; $display("FAIL equal_order[%0d]: got %0d want %0d", c, g_o, c % N); end
            total++; if (v_o !== 1'b1 || d_o !== d_e) begin bad++; $display("FAIL equal_tlp[%0d]: got %b/%h want 1/%h", c, v_o, d_o, d_e); end
        end
    endtask

    task automatic test_weighted();
        int ord[7] = '{0, 0, 0, 1, 2, 2, 3};
        restart(3, 1, 2, 1);
        for (int i = 0; i < N; i++) repeat (20) q[i].push_back(rnd_tlp());
        for (int c = 0; c < 14; c++) begin
            cycle();
            total++; if (g_o !== ord[c % 7]) begin bad++; $display("FAIL weighted_order[%0d]: got %0d want %0d", c, g_o, ord[c % 7]); end
            total++; if (d_o !== d_e) begin bad++; $display("FAIL weighted_tlp[%0d]: got %h want %h", c, d_o, d_e); end
        end
    endtask

    task automatic test_backpressure();
        tlp_t held;
        restart(1, 1, 1, 1);
        for (int i = 0; i < N; i++) repeat (4) q[i].push_back(rnd_tlp());
        cycle();
        held = d_e;
        total++; if (v_o !== 1'b1 || d_o !== held) begin bad++; $display("FAIL stall_first: got %b/%h want 1/%h", v_o, d_o, held); end
        rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            total++; if (rd_o !== '0) begin bad++; $display("FAIL stall_rd_en[%0d]: got %b want 0", c, rd_o); end
            total++; if (v_o !== 1'b1 || d_o !== held) begin bad++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/%h", c, v_o, d_o, held); end
        end
        rdy = 1'b1;
        cycle();
        total++; if (g_o !== 1) begin bad++; $display("FAIL stall_resume_grant: got %0d want 1", g_o); end
        total++; if (d_o !== d_e || d_o === held) begin bad++; $display("FAIL stall_resume_tlp: got %h want %h", d_o, d_e); end
    endtask

    task automatic test_single_vc();
        restart(1, 1, 1, 1);
        repeat (3) q[2].push_back(rnd_tlp());
        for (int c = 0; c < 4; c++) begin
            cycle();
            total++; if (g_o !== ((c < 3) ? 2 : -1)) begin bad++; $display("FAIL single_grant[%0d]: got %0d want %0d", c, g_o, (c < 3) ? 2 : -1); end
            total++; if (v_o !== (c < 3) || d_o !== d_e) begin bad++; $display("FAIL single_out[%0d]: got %b/%h want %b/%h", c, v_o, d_o, v_e, d_e); end
        end
    endtask

    task automatic test_reset_mid_burst();
        restart(1, 4, 1, 1);
        repeat (6) q[1].push_back(rnd_tlp());
        for (int c = 0; c < 2; c++) begin
            cycle();
            total++; if (g_o !== 1) begin bad++; $display("FAIL midrst_burst[%0d]: got %0d want 1", c, g_o); end
        end
        repeat (2) q[0].push_back(rnd_tlp());
        rst = 1'b1;
        cycle();
        total++; if (rd_o !== '0)  begin bad++; $display("FAIL midrst_rd_en: got %b want 0", rd_o); end
        total++; if (v_o !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", v_o); end
        rst = 1'b0;
        cycle();
        total++; if (g_o !== 0) begin bad++; $display("FAIL midrst_first_grant: got %0d want 0", g_o); end
        total++; if (v_o !== 1'b1 || d_o !== d_e) begin bad++; $display("FAIL midrst_tlp: got %b/%h want 1/%h", v_o, d_o, d_e); end
    endtask

`ifdef ARB_STRICT_VC0_EN
    task automatic test_strict_vc0();
        restart(1, 1, 1, 4);
        repeat (6) q[3].push_back(rnd_tlp());
        for (int c = 0; c < 2; c++) begin
            cycle();
            total++; if (g_o !== 3) begin bad++; $display("FAIL strict_burst[%0d]: got %0d want 3", c, g_o); end
        end
        q[0].push_back(rnd_tlp());
        cycle();
        total++; if (g_o !== 0) begin bad++; $display("FAIL strict_preempt: got %0d want 0", g_o); end
        total++; if (d_o !== d_e) begin bad++; $display("FAIL strict_tlp: got %h want %h", d_o, d_e); end
        cycle();
        total++; if (rd_o !== rd_e) begin bad++; $display("FAIL strict_after: got %b want %b", rd_o, rd_e); end
    endtask
`endif

    task automatic test_random();
        restart($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5));
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 49) == 0)
                for (int i = 0; i < N; i++) w[i] = $urandom_range(0, 5);
            for (int i = 0; i < N; i++)
                if (q[i].size() < 6 && $urandom_range(0, 2) == 0) q[i].push_back(rnd_tlp());
            rdy = ($urandom_range(0, 3) != 0);
            cycle();
            total++; if (rd_o !== rd_e) begin bad++; $display("FAIL rand_rd_en[%0d]: got %b want %b", c, rd_o, rd_e); end
            total++; if (v_o !== v_e || d_o !== d_e) begin bad++; $display("FAIL rand_out[%0d]: got %b/%h want %b/%h", c, v_o, d_o, v_e, d_e); end
        end
    endtask

    initial begin
        test_reset();
        test_equal_weights();
        test_weighted();
        test_backpressure();
        test_single_vc();
        test_reset_mid_burst();
`ifdef ARB_STRICT_VC0_EN
        test_strict_vc0();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_wrr_tlp.md
ARB_WRR_TLP -- requirements
Module: arb_wrr_tlp

Interface
REQ-001 SHALL have parameter NUM_VC, default 4: number of virtual-channel FIFOs arbitrated, legal 2..8.
REQ-002 SHALL have parameter TLP_W, default 224: TLP data width.
REQ-003 SHALL have parameter WEIGHT_W, default 4: width of each per-VC weight.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port vc_empty, input, NUM_VC: per-VC FIFO empty flag, show-ahead FIFOs.
REQ-007 SHALL have port vc_data, input, NUM_VC*TLP_W: per-VC head TLP; VC i occupies bits [i*TLP_W +: TLP_W].
REQ-008 SHALL have port vc_weight, input, NUM_VC*WEIGHT_W: per-VC burst weight, quasi-static.
REQ-009 SHALL have port vc_rd_en, output, NUM_VC: one-hot-or-zero pop strobe to the VC FIFOs.
REQ-010 SHALL have port tlp_o, output, TLP_W: registered TLP toward the link layer.
REQ-011 SHALL have port tlp_valid_o, output, 1: tlp_o holds a TLP.
REQ-012 SHALL have port tlp_ready_i, input, 1: downstream accepts tlp_o when high together with tlp_valid_o.

Function
REQ-013 SHALL compute load = !tlp_valid_o || tlp_ready_i; a TLP is captured only when load is high and a grant exists.
REQ-014 SHALL drive vc_rd_en combinationally: bit g high only in a capture cycle, where g is the granted VC; at most one bit high.
REQ-015 SHALL register vc_data of g into tlp_o and set tlp_valid_o on the capture edge, giving 1-cycle latency from FIFO head to tlp_o.
REQ-016 SHALL hold tlp_o and tlp_valid_o stable while tlp_valid_o && !tlp_ready_i.
REQ-017 SHALL clear tlp_valid_o when load is high and no VC is non-empty; tlp_o then keeps its last value.
REQ-018 SHALL implement a two-state FSM: IDLE (no current owner) and BURST (owner cur_vc, credit counter cnt).
REQ-019 IDLE: the grant goes to the first non-empty VC searching from ptr upward with wrap-around at NUM_VC-1; on capture the FSM goes to BURST with cur_vc=g and cnt=max(weight[g],1)-1.
REQ-020 BURST: the grant goes to cur_vc while it is non-empty and cnt>0; each capture decrements cnt.
REQ-021 SHALL end a burst when cnt==0 at capture or when cur_vc is empty at a load opportunity; ptr then becomes cur_vc+1 modulo NUM_VC, and the FSM goes to IDLE.
REQ-022 SHALL re-arbitrate from IDLE in the same cycle a burst ends, so a single non-empty VC is re-granted back-to-back without a bubble.
REQ-023 SHALL treat weight 0 as 1 and sample vc_weight only at burst start, so changes made mid-burst apply to the next burst.
REQ-024 SHALL never pop a FIFO whose vc_empty is high.

Reset
REQ-025 On rst the block SHALL set tlp_valid_o=0, tlp_o=0, FSM=IDLE, ptr=0, cnt=0, and vc_rd_en=0.
REQ-026 A TLP held in tlp_o when rst asserts SHALL be discarded, not replayed.

Configuration
REQ-027 With macro ARB_STRICT_VC0_EN defined, a non-empty VC0 SHALL pre-empt any IDLE or BURST decision; an interrupted burst is dropped, ptr is unchanged, and VC0 grants do not touch cnt.
REQ-028 Without ARB_STRICT_VC0_EN, VC0 SHALL be an ordinary weighted round-robin participant.

Structure
REQ-029 Package pcie_tx_pkg SHALL hold the TLP_W default constant, the MAX_VC=8 constant, and the FSM state enum typedef.
REQ-030 A sub-module arb_rr_pick SHALL implement the rotated find-first-set: inputs request vector and ptr, outputs grant index and any-request flag.

Verification
REQ-031 Bench SHALL cover: NUM_VC=4, weights 1,1,1,1, all FIFOs full, ready=1 -> grant order 0,1,2,3,0..., one TLP per cycle.
REQ-032 Bench SHALL cover: weights 3,1,2,1, all VCs backlogged -> order 0,0,0,1,2,2,3, repeating.
REQ-033 Bench SHALL cover: ready held low for 5 cycles after a capture -> tlp_o stable, vc_rd_en=0, no pops; the next TLP follows the cycle after ready rises.
REQ-034 Bench SHALL cover: only VC2 non-empty with 3 entries, weight 1 -> three consecutive pops of VC2, then tlp_valid_o=0.
REQ-035 Bench SHALL cover: rst asserted mid-burst of VC1 -> next cycle tlp_valid_o=0, and the first grant after release goes to VC0 if non-empty.
REQ-036 Bench SHALL cover, with ARB_STRICT_VC0_EN defined: VC0 becomes non-empty during a VC3 burst -> VC0 granted the next load cycle.
